// File: rtl/lsu.sv
// RV32I load/store unit: turns an ALU effective address into a single word-wide
// request/acknowledge bus transaction with lane steering and load extension.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic        stall,
  output logic        done,
  output logic [31:0] readdata,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_e;

  localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYCLES);
  localparam bit          TimeoutEn  = (TIMEOUT_CYCLES != 0);

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] readdata_q, readdata_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;

  logic        access;
  logic        illegal;
  logic        misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Request decode: legality, alignment and store lane steering.
  always_comb begin
    access     = req_valid & (memread | memwrite);
    illegal    = 1'b0;
    misaligned = 1'b0;
    st_wdata   = writedata;
    st_wstrb   = 4'b1111;

    if (memread && memwrite) begin
      illegal = 1'b1;
    end else if (memread) begin
      illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else begin
      illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
    end

    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase

    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{writedata[7:0]}};
        st_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{writedata[15:0]}};
        st_wstrb = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = writedata;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load extraction uses the offset and width latched when the request launched.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus_rdata;
    endcase
  end

  // NOTE: every _d starts as its _q so no path through the case leaves a
  // variable unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    readdata_d  = readdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    f3_d        = f3_q;

    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (illegal || misaligned) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = memwrite;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_wdata_d = memwrite ? st_wdata : 32'd0;
            bus_wstrb_d = memwrite ? st_wstrb : 4'b0000;
            cnt_d       = 16'd0;
            off_d       = addr[1:0];
            f3_d        = funct3;
            state_d     = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          err_d     = 1'b0;
          if (!bus_we_q) begin
            readdata_d = ld_data;
          end
          state_d = S_DONE;
        end else if (TimeoutEn && (cnt_q == TimeoutLim)) begin
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; all of it clears on reset, including the data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_wstrb_q <= 4'b0000;
      readdata_q  <= 32'd0;
      err_q       <= 1'b0;
      cnt_q       <= 16'd0;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      readdata_q  <= readdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
    end
  end

  assign done      = (state_q == S_DONE);
  assign stall     = req_valid & (memread | memwrite) & ~done;
  assign readdata  = readdata_q;
  assign err       = err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a transaction-level model of
// the access rules, with a short timeout so the abort path is reachable.
module tb_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic        stall;
  logic        done;
  logic [31:0] readdata;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_rd  = 32'd0;
  logic        exp_err = 1'b0;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .memread   (memread),
    .memwrite  (memwrite),
    .funct3    (funct3),
    .addr      (addr),
    .writedata (writedata),
    .stall     (stall),
    .done      (done),
    .readdata  (readdata),
    .err       (err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wstrb (bus_wstrb),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_bus_req"},   bus_req,   0);
    check({pfx, "_bus_we"},    bus_we,    0);
    check({pfx, "_bus_addr"},  bus_addr,  0);
    check({pfx, "_bus_wdata"}, bus_wdata, 0);
    check({pfx, "_bus_wstrb"}, bus_wstrb, 0);
    check({pfx, "_readdata"},  readdata,  0);
    check({pfx, "_done"},      done,      0);
    check({pfx, "_err"},       err,       0);
  endtask

  // One complete access: drive, act as the bus with a given ack delay, and
  // compare against the model outcome.
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int dly, input logic [31:0] rdata);
    bit          legal;
    bit          mis;
    int          nbytes;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
    int          req_cycles;
    int          exp_cycles;
    bit          seen_done;
    bit          timeout;
    logic [1:0]  off;

    off    = a[1:0];
    nbytes = 1 << f3[1:0];
    if (rd && wr)  legal = 1'b0;
    else if (rd)   legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    else           legal = (f3 <= 3'd2);
    mis = legal && ((a % nbytes) != 0);

    exp_wdata = wd;
    exp_strb  = 4'b1111;
    if (f3[1:0] == 2'd0) begin
      exp_wdata = (wd & 32'hFF) * 32'h0101_0101;
      exp_strb  = 4'(1 << off);
    end else if (f3[1:0] == 2'd1) begin
      exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
      exp_strb  = 4'(3 << off);
    end

    @(negedge clk);
    bus_ack   = 1'b0;
    req_valid = 1'b1;
    memread   = rd;
    memwrite  = wr;
    funct3    = f3;
    addr      = a;
    writedata = wd;
    #1;
    check("stall_issue", stall, 1);

    if (!legal || mis) begin
      @(negedge clk);
      check("fault_done",    done,     1);
      check("fault_err",     err,      1);
      check("fault_bus_req", bus_req,  0);
      check("fault_stall",   stall,    0);
      check("fault_rd_hold", readdata, exp_rd);
      exp_err = 1'b1;
    end else begin
      timeout    = (dly > TO);
      exp_cycles = timeout ? TO + 1 : dly + 1;
      req_cycles = 0;
      seen_done  = 1'b0;
      for (int c = 0; c < 100 && !seen_done; c++) begin
        @(negedge clk);
        bus_ack = 1'b0;
        if (done) begin
          seen_done = 1'b1;
        end else if (bus_req) begin
          req_cycles++;
          check("req_addr", bus_addr, a & 32'hFFFF_FFFC);
          check("req_we",   bus_we,   wr);
          check("req_strb", bus_wstrb, wr ? exp_strb : 4'b0000);
          if (wr) check("req_wdata", bus_wdata, exp_wdata);
          if (req_cycles == 1) check("req_stall", stall, 1);
          if (req_cycles - 1 == dly) begin
            bus_ack   = 1'b1;
            bus_rdata = rdata;
          end
        end
      end
      check("done_seen",    seen_done,  1);
      check("req_cycles",   req_cycles, exp_cycles);
      if (!timeout && rd) exp_rd = extend(f3, off, rdata);
      exp_err = timeout;
      check("done_err",     err,      exp_err);
      check("done_rdata",   readdata, exp_rd);
      check("done_stall",   stall,    0);
      check("done_bus_req", bus_req,  0);
    end

    req_valid = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    bus_ack   = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("idle_done",  done,     0);
    check("idle_req",   bus_req,  0);
    check("idle_rdata", readdata, exp_rd);
    check("idle_err",   err,      exp_err);
    bus_ack = 1'b0;
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_stall", stall, 0);

    run_access(1, 0, 3'b010, 32'h0000_0100, 32'd0, 0, 32'hDEAD_BEEF);
    check("lw_rdata", readdata, 32'hDEAD_BEEF);
    run_access(1, 0, 3'b000, 32'h0000_0103, 32'd0, 1, 32'h80FF_1234);
    check("lb_rdata", readdata, 32'hFFFF_FF80);
    run_access(1, 0, 3'b100, 32'h0000_0103, 32'd0, 2, 32'h80FF_1234);
    check("lbu_rdata", readdata, 32'h0000_0080);
    run_access(0, 1, 3'b000, 32'h0000_0102, 32'h0000_00A5, 0, 32'd0);
    run_access(0, 1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 1, 32'd0);
    run_access(1, 0, 3'b010, 32'h0000_0101, 32'd0, 0, 32'd0);
    run_access(1, 0, 3'b011, 32'h0000_0100, 32'd0, 0, 32'd0);
    run_access(0, 1, 3'b001, 32'h0000_0105, 32'h5555_5555, 0, 32'd0);
    run_access(1, 1, 3'b010, 32'h0000_0200, 32'd0, 0, 32'd0);
    run_access(1, 0, 3'b010, 32'h0000_0300, 32'd0, 20, 32'h1111_1111);
    check("timeout_err", err, 1);
    run_access(1, 0, 3'b010, 32'h0000_0304, 32'd0, 3, 32'hCAFE_F00D);
    check("after_to_err", err, 0);
    run_access(1, 0, 3'b001, 32'h0000_0402, 32'd0, TO, 32'h8001_7FFF);

    for (int i = 0; i < 60; i++) begin
      bit          rd;
      bit          wr;
      logic [2:0]  f3;
      int          sel;
      sel = $urandom_range(0, 15);
      rd  = (sel < 8) || (sel == 15);
      wr  = (sel >= 8);
      f3  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
          : (rd ? 3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2) & 3'b100
                : 3'($urandom_range(0, 2)));
      run_access(rd, wr, f3, $urandom, $urandom, $urandom_range(0, TO + 2), $urandom);
    end

    @(negedge clk);
    req_valid = 1'b1;
    memread   = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h0000_0500;
    @(negedge clk);
    check("pre_reset_req", bus_req, 1);
    req_valid = 1'b0;
    memread   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n   = 1'b1;
    exp_rd  = 32'd0;
    exp_err = 1'b0;
    @(negedge clk);
    check_all_zero("postreset");
    check("postreset_stall", stall, 0);
    run_access(0, 1, 3'b010, 32'h0000_0600, 32'h0BAD_F00D, 2, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
